// File: rtl/mall_occupancy_tracker_if.sv
// Sensor inputs, clear, and all occupancy outputs of the mall occupancy tracker.
// The master side (gate controller / bench) drives the sensors and clear.
// The slave side (the tracker) drives counts and flags.
interface mall_occupancy_tracker_if #(
  parameter int NUM_GATES   = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int TOTAL_WIDTH = 16
);
  logic [NUM_GATES-1:0]   entry_sensor;
  logic [NUM_GATES-1:0]   exit_sensor;
  logic                   clear;
  logic [CNT_WIDTH-1:0]   occupancy;
  logic [TOTAL_WIDTH-1:0] total_entries;
  logic [TOTAL_WIDTH-1:0] total_exits;
  logic                   full;
  logic                   almost_full;
  logic                   empty;
  logic                   entry_allow;
  logic                   overflow_err;
  logic                   underflow_err;

  modport master (
    output entry_sensor, exit_sensor, clear,
    input  occupancy, total_entries, total_exits, full, almost_full,
           empty, entry_allow, overflow_err, underflow_err
  );

  modport slave (
    input  entry_sensor, exit_sensor, clear,
    output occupancy, total_entries, total_exits, full, almost_full,
           empty, entry_allow, overflow_err, underflow_err
  );
endinterface

// File: rtl/mall_occupancy_tracker.sv
// Multi-gate occupancy counter.
// Each sensor bit passes through a two-flop synchroniser and a rising-edge
// detector. Per-cycle entry/exit counts are netted against the occupancy and
// then clamped to [0, CAPACITY]. Sticky error flags record any clamping.
module mall_occupancy_tracker #(
  parameter int NUM_GATES          = 2,
  parameter int CNT_WIDTH          = 8,
  parameter int CAPACITY           = 200,
  parameter int ALMOST_FULL_MARGIN = 10,
  parameter int TOTAL_WIDTH        = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  mall_occupancy_tracker_if.slave   bus
);

  // Signed sum width: headroom for adding NUM_GATES and subtracting NUM_GATES
  // without wrapping.
  localparam int SUM_WIDTH = CNT_WIDTH + $clog2(NUM_GATES) + 2;
  localparam int POP_WIDTH = $clog2(NUM_GATES + 1);
  localparam int AF_LEVEL  = CAPACITY - ALMOST_FULL_MARGIN;
  localparam logic signed [SUM_WIDTH-1:0] CAP_SUM = SUM_WIDTH'(CAPACITY);

  logic [NUM_GATES-1:0]   entry_s1_reg, entry_s2_reg, entry_s3_reg;
  logic [NUM_GATES-1:0]   exit_s1_reg, exit_s2_reg, exit_s3_reg;
  logic [NUM_GATES-1:0]   entry_event, exit_event;
  logic [POP_WIDTH-1:0]   entry_count, exit_count;

  logic signed [SUM_WIDTH-1:0] occ_sum;
  logic [CNT_WIDTH-1:0]   occupancy_reg, occupancy_next;
  logic                   overflow_reg, overflow_next;
  logic                   underflow_reg, underflow_next;
  logic [TOTAL_WIDTH-1:0] total_entries_reg, total_exits_reg;
  logic                   full_flag;

  // Synchronise the asynchronous sensor levels and keep one extra stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry_s1_reg <= '0;
      entry_s2_reg <= '0;
      entry_s3_reg <= '0;
      exit_s1_reg  <= '0;
      exit_s2_reg  <= '0;
      exit_s3_reg  <= '0;
    end else begin
      entry_s1_reg <= bus.entry_sensor;
      entry_s2_reg <= entry_s1_reg;
      entry_s3_reg <= entry_s2_reg;
      exit_s1_reg  <= bus.exit_sensor;
      exit_s2_reg  <= exit_s1_reg;
      exit_s3_reg  <= exit_s2_reg;
    end
  end

  // One event per synchronised rising edge; a held level counts once.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GATES; gi++) begin : g_gate
      assign entry_event[gi] = entry_s2_reg[gi] & ~entry_s3_reg[gi];
      assign exit_event[gi]  = exit_s2_reg[gi]  & ~exit_s3_reg[gi];
    end
  endgenerate

  // Population count of this cycle's entry and exit events.
  always_comb begin
    entry_count = '0;
    exit_count  = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      entry_count = entry_count + POP_WIDTH'(entry_event[i]);
      exit_count  = exit_count  + POP_WIDTH'(exit_event[i]);
    end
  end

  // Net entries and exits first, then clamp; errors are sticky.
  always_comb begin
    occ_sum        = SUM_WIDTH'(occupancy_reg) + SUM_WIDTH'(entry_count)
                   - SUM_WIDTH'(exit_count);
    occupancy_next = occ_sum[CNT_WIDTH-1:0];
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (occ_sum[SUM_WIDTH-1]) begin
      occupancy_next = '0;
      underflow_next = 1'b1;
    end else if (occ_sum > CAP_SUM) begin
      occupancy_next = CNT_WIDTH'(CAPACITY);
      overflow_next  = 1'b1;
    end
  end

  // Counter state; clear wins over any event arriving the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy_reg     <= '0;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
      total_entries_reg <= '0;
      total_exits_reg   <= '0;
    end else if (bus.clear) begin
      occupancy_reg     <= '0;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
      total_entries_reg <= '0;
      total_exits_reg   <= '0;
    end else begin
      occupancy_reg     <= occupancy_next;
      overflow_reg      <= overflow_next;
      underflow_reg     <= underflow_next;
      total_entries_reg <= total_entries_reg + TOTAL_WIDTH'(entry_count);
      total_exits_reg   <= total_exits_reg + TOTAL_WIDTH'(exit_count);
    end
  end

  assign full_flag = (occupancy_reg == CNT_WIDTH'(CAPACITY));

  // Threshold at or below zero means the mall is always "almost full".
  generate
    if (AF_LEVEL <= 0) begin : g_af_always
      assign bus.almost_full = 1'b1;
    end else begin : g_af_cmp
      assign bus.almost_full = (occupancy_reg >= CNT_WIDTH'(AF_LEVEL));
    end
  endgenerate

  assign bus.occupancy     = occupancy_reg;
  assign bus.total_entries = total_entries_reg;
  assign bus.total_exits   = total_exits_reg;
  assign bus.full          = full_flag;
  assign bus.empty         = (occupancy_reg == '0);
  assign bus.entry_allow   = ~full_flag;
  assign bus.overflow_err  = overflow_reg;
  assign bus.underflow_err = underflow_reg;

endmodule

// File: tb/tb_mall_occupancy_tracker.sv
// Bench for mall_occupancy_tracker: a per-cycle scoreboard fed by a reference
// model, a table of pulse vectors with hand-computed end states, and
// hand-written clear and asynchronous-reset sequences.
module tb_mall_occupancy_tracker;

  localparam int CAP = 200;
  localparam int AFL = 190;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  mall_occupancy_tracker_if #(.NUM_GATES(2), .CNT_WIDTH(8), .TOTAL_WIDTH(16)) bus ();

  mall_occupancy_tracker #(
    .NUM_GATES(2), .CNT_WIDTH(8), .CAPACITY(CAP),
    .ALMOST_FULL_MARGIN(10), .TOTAL_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard record: expected state visible at negedge with cyc == due.
  typedef struct {
    int          due;
    int          occ;
    logic [15:0] te;
    logic [15:0] tx;
    logic        ov;
    logic        un;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state.
  int          m_occ;
  logic [15:0] m_te, m_tx;
  logic        m_ov, m_un;
  logic [1:0]  prev_en, prev_ex;
  int          pipe_e[2];
  int          pipe_x[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_te = '0; m_tx = '0; m_ov = 1'b0; m_un = 1'b0;
    prev_en = '0; prev_ex = '0;
    pipe_e[0] = 0; pipe_e[1] = 0; pipe_x[0] = 0; pipe_x[1] = 0;
  endtask

  // Drive one cycle of sensor levels and clear, and predict the state after the next edge.
  task automatic step(input logic [1:0] en, input logic [1:0] ex, input logic clr);
    int e, x, n;
    exp_t r;
    @(negedge clock);
    bus.entry_sensor = en;
    bus.exit_sensor  = ex;
    bus.clear        = clr;
    // A rise sampled now is counted at the edge two steps later.
    e = pipe_e[1]; x = pipe_x[1];
    pipe_e[1] = pipe_e[0]; pipe_x[1] = pipe_x[0];
    pipe_e[0] = $countones(en & ~prev_en);
    pipe_x[0] = $countones(ex & ~prev_ex);
    prev_en = en; prev_ex = ex;
    if (clr) begin
      m_occ = 0; m_te = '0; m_tx = '0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      n = m_occ + e - x;
      if (n > CAP) begin
        m_occ = CAP; m_ov = 1'b1;
      end else if (n < 0) begin
        m_occ = 0; m_un = 1'b1;
      end else begin
        m_occ = n;
      end
      m_te = m_te + 16'(e);
      m_tx = m_tx + 16'(x);
    end
    r.due = cyc + 1; r.occ = m_occ; r.te = m_te; r.tx = m_tx; r.ov = m_ov; r.un = m_un;
    sb_q.push_back(r);
  endtask

  // Pulse a gate mask high for 'hold' cycles, then low for one, 'reps' times; then settle.
  task automatic pulse(input logic [1:0] en, input logic [1:0] ex, input int reps, input int hold);
    for (int r = 0; r < reps; r++) begin
      for (int h = 0; h < hold; h++) step(en, ex, 1'b0);
      step(2'b00, 2'b00, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 1'b0);
  endtask

  // Scoreboard monitor: compare the predicted state when the DUT should show it.
  always @(negedge clock) begin
    exp_t r;
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      r = sb_q.pop_front();
      if (r.due != cyc) chk("sb_due", 32'(cyc), 32'(r.due));
      chk("sb_occ",   32'(bus.occupancy),     32'(r.occ));
      chk("sb_te",    32'(bus.total_entries), 32'(r.te));
      chk("sb_tx",    32'(bus.total_exits),   32'(r.tx));
      chk("sb_ov",    32'(bus.overflow_err),  32'(r.ov));
      chk("sb_un",    32'(bus.underflow_err), 32'(r.un));
      chk("sb_full",  32'(bus.full),          32'(r.occ == CAP));
      chk("sb_af",    32'(bus.almost_full),   32'(r.occ >= AFL));
      chk("sb_empty", 32'(bus.empty),         32'(r.occ == 0));
      chk("sb_allow", 32'(bus.entry_allow),   32'(r.occ != CAP));
      $display("sb cyc=%0d occ=%0d te=%0d tx=%0d ov=%0d un=%0d",
               cyc, bus.occupancy, bus.total_entries, bus.total_exits,
               bus.overflow_err, bus.underflow_err);
    end
  end

  typedef struct {
    logic [1:0] en;
    logic [1:0] ex;
    int         reps;
    int         hold;
    int         occ;
    int         te;
    int         tx;
    logic       ov;
    logic       un;
    logic       full;
    logic       af;
    logic       empty;
  } vec_t;

  vec_t tbl[12];

  task automatic check_state(input string tag, input int occ, input int te, input int tx,
                             input logic ov, input logic un);
    chk({tag, "_occ"}, 32'(bus.occupancy),     32'(occ));
    chk({tag, "_te"},  32'(bus.total_entries), 32'(te));
    chk({tag, "_tx"},  32'(bus.total_exits),   32'(tx));
    chk({tag, "_ov"},  32'(bus.overflow_err),  32'(ov));
    chk({tag, "_un"},  32'(bus.underflow_err), 32'(un));
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    reset = 1'b0;
    bus.entry_sensor = '0; bus.exit_sensor = '0; bus.clear = 1'b0;
    model_reset();

    //                 en     ex     reps hold occ  te   tx  ov  un  full af empty
    tbl[0]  = '{2'b01, 2'b00,   1,  2,   1,   1,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b11, 2'b00,   5,  2,  11,  11,   0, 0, 0, 0, 0, 0};
    tbl[2]  = '{2'b00, 2'b10,   1,  2,  10,  11,   1, 0, 0, 0, 0, 0};
    tbl[3]  = '{2'b01, 2'b00,   1, 20,  11,  12,   1, 0, 0, 0, 0, 0};
    tbl[4]  = '{2'b11, 2'b00,  89,  2, 189, 190,   1, 0, 0, 0, 0, 0};
    tbl[5]  = '{2'b01, 2'b00,   1,  2, 190, 191,   1, 0, 0, 0, 1, 0};
    tbl[6]  = '{2'b11, 2'b00,   5,  2, 200, 201,   1, 0, 0, 1, 1, 0};
    tbl[7]  = '{2'b01, 2'b01,   1,  2, 200, 202,   2, 0, 0, 1, 1, 0};
    tbl[8]  = '{2'b01, 2'b00,   1,  2, 200, 203,   2, 1, 0, 1, 1, 0};
    tbl[9]  = '{2'b00, 2'b11, 100,  2,   0, 203, 202, 1, 0, 0, 0, 1};
    tbl[10] = '{2'b00, 2'b01,   1,  2,   0, 203, 203, 1, 1, 0, 0, 1};
    tbl[11] = '{2'b11, 2'b00,  25,  2,  50, 253, 203, 1, 1, 0, 0, 0};

    // Reset state while reset is held.
    repeat (2) @(negedge clock);
    check_state("rst", 0, 0, 0, 1'b0, 1'b0);
    chk("rst_empty", 32'(bus.empty),       32'd1);
    chk("rst_full",  32'(bus.full),        32'd0);
    chk("rst_af",    32'(bus.almost_full), 32'd0);
    chk("rst_allow", 32'(bus.entry_allow), 32'd1);
    reset = 1'b1;

    // Table of pulse patterns with hand-computed end states.
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].en, tbl[i].ex, tbl[i].reps, tbl[i].hold);
      check_state($sformatf("row%0d", i), tbl[i].occ, tbl[i].te, tbl[i].tx, tbl[i].ov, tbl[i].un);
      chk($sformatf("row%0d_full", i),  32'(bus.full),        32'(tbl[i].full));
      chk($sformatf("row%0d_af", i),    32'(bus.almost_full), 32'(tbl[i].af));
      chk($sformatf("row%0d_empty", i), 32'(bus.empty),       32'(tbl[i].empty));
      chk($sformatf("row%0d_allow", i), 32'(bus.entry_allow), 32'(!tbl[i].full));
      $display("row %0d occ=%0d te=%0d tx=%0d", i, bus.occupancy, bus.total_entries, bus.total_exits);
    end

    // Clear lands on the same cycle as an entry event: the entry is discarded.
    step(2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b00, 1'b0);
    check_state("clr", 0, 0, 0, 1'b0, 1'b0);
    chk("clr_empty", 32'(bus.empty), 32'd1);
    $display("clear occ=%0d te=%0d", bus.occupancy, bus.total_entries);

    // Asynchronous reset between edges while an entry edge is in flight.
    pulse(2'b01, 2'b00, 1, 2);
    check_state("pre", 1, 1, 0, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    bus.entry_sensor = '0;
    sb_q.delete();
    model_reset();
    #1;
    check_state("arst", 0, 0, 0, 1'b0, 1'b0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_allow", 32'(bus.entry_allow), 32'd1);
    $display("async reset occ=%0d empty=%0d", bus.occupancy, bus.empty);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) step(2'b00, 2'b00, 1'b0);
    check_state("post", 0, 0, 0, 1'b0, 1'b0);

    // Let the scoreboard drain, bounded.
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clock);
    @(posedge clock);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
